// File: rtl/sign_magnitude_addsub_pipe_if.sv
// Operand/result handshake bundle for the sign-magnitude add/sub pipeline.
interface sign_magnitude_addsub_pipe_if #(
    parameter int unsigned DATA_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  op_sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH:0]   sum;
    logic                  zero;

    // Operand source / result sink side
    modport master (
        output in_valid, a, b, op_sub, out_ready,
        input  in_ready, out_valid, sum, zero
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, op_sub, out_ready,
        output in_ready, out_valid, sum, zero
    );
endinterface

// File: rtl/sign_magnitude_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor; magnitudes come from constant
// sum / |difference| tables indexed by {a_mag, b_mag}. Valid/ready with a
// single global enable so a stalled output freezes the whole pipe.
module sign_magnitude_addsub_pipe #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input logic                          clk,
    input logic                          rst_n,
    sign_magnitude_addsub_pipe_if.slave  bus
);
    localparam int unsigned M         = DATA_WIDTH - 1;
    localparam int unsigned AW        = 2 * M;
    localparam int unsigned ROM_DEPTH = 1 << AW;
    localparam int unsigned MW        = M + 1;

    logic [MW-1:0] sum_rom  [ROM_DEPTH];
    logic [MW-1:0] diff_rom [ROM_DEPTH];

    // Table contents are elaboration constants derived from the entry index
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        localparam int unsigned AM = gi >> M;
        localparam int unsigned BM = gi & ((1 << M) - 1);
        assign sum_rom[gi]  = MW'(AM + BM);
        assign diff_rom[gi] = MW'((AM > BM) ? (AM - BM) : (BM - AM));
    end

    logic [M-1:0]  a_mag_c;
    logic [M-1:0]  b_mag_c;
    logic          sb_c;
    logic          ss_c;
    logic          en_c;

    logic          s1_valid_q;
    logic [AW-1:0] addr_q;
    logic          a_sign_q;
    logic          sb_q;
    logic          ss_q;
    logic          gt_q;
    logic          eq_q;

    logic [MW-1:0] mag_d;
    logic          mag_zero_d;
    logic          sign_d;

    logic          out_valid_q;
    logic [MW:0]   sum_q;
    logic          zero_q;

    // Operand decode: effective B sign folds in the subtract request
    assign a_mag_c = bus.a[M-1:0];
    assign b_mag_c = bus.b[M-1:0];
    assign sb_c    = bus.b[M] ^ bus.op_sub;
    assign ss_c    = (bus.a[M] == sb_c);
    assign en_c    = !out_valid_q || bus.out_ready;

    // Stage 1: register table address and sign-selection flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            addr_q     <= '0;
            a_sign_q   <= 1'b0;
            sb_q       <= 1'b0;
            ss_q       <= 1'b0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
        end else if (en_c) begin
            s1_valid_q <= bus.in_valid;
            addr_q     <= {a_mag_c, b_mag_c};
            a_sign_q   <= bus.a[M];
            sb_q       <= sb_c;
            ss_q       <= ss_c;
            gt_q       <= (a_mag_c > b_mag_c);
            eq_q       <= (a_mag_c == b_mag_c);
        end
    end

    // Stage 2 datapath: table lookup and sign resolution, never emitting -0
    always_comb begin
        mag_d      = '0;
        mag_zero_d = 1'b0;
        sign_d     = 1'b0;
        if (ss_q) begin
            mag_d      = sum_rom[addr_q];
            mag_zero_d = (mag_d == '0);
            sign_d     = a_sign_q;
        end else begin
            mag_d      = diff_rom[addr_q];
            mag_zero_d = eq_q;
            sign_d     = gt_q ? a_sign_q : sb_q;
        end
        if (mag_zero_d) begin
            sign_d = 1'b0;
        end
    end

    // Stage 2: result register, held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            zero_q      <= 1'b0;
        end else if (en_c) begin
            out_valid_q <= s1_valid_q;
            sum_q       <= {sign_d, mag_d};
            zero_q      <= mag_zero_d;
        end
    end

    assign bus.in_ready  = en_c;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_sign_magnitude_addsub_pipe.sv
// Randomized and directed bench for sign_magnitude_addsub_pipe with a
// signed-integer reference model and an in-order result scoreboard.
module tb_sign_magnitude_addsub_pipe;
    localparam int unsigned DW = 4;
    localparam int unsigned M  = DW - 1;

    logic clk;
    logic rst_n;

    sign_magnitude_addsub_pipe_if #(.DATA_WIDTH(DW)) bus ();

    sign_magnitude_addsub_pipe #(.DATA_WIDTH(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;

    // Expected {zero, sign, mag} for every accepted operand pair, in order
    logic [DW+1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: interpret operands as signed integers and do plain arithmetic
    function automatic logic [DW+1:0] ref_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic op);
        int va;
        int vb;
        int r;
        int mag;
        va = int'(a[M-1:0]);
        vb = int'(b[M-1:0]);
        if (a[M]) va = -va;
        if (b[M]) vb = -vb;
        r   = op ? (va - vb) : (va + vb);
        mag = (r < 0) ? -r : r;
        return {(r == 0), (r < 0), DW'(mag)};
    endfunction

    // Scoreboard: compare visible results, record accepted operands
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    check_eq("result", 32'({bus.zero, bus.sum}), 32'(exp_q[0]));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        rx_cnt++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(bus.a, bus.b, bus.op_sub));
            end
        end
    end

    task automatic drain(input string tag);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Single op into an idle pipe: check 2-cycle latency and literal result
    task automatic run_directed(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic op, input logic [DW:0] exp_sum, input logic exp_zero);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op_sub   = op;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_lat2_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check_eq({tag, "_zero"}, 32'(bus.zero), 32'(exp_zero));
        drain({tag, "_drain"});
    endtask

    logic [DW-1:0] sa[6];
    logic [DW-1:0] sb[6];
    logic          sop[6];
    int            base;
    int            idx;
    logic          fire;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_sum", 32'(bus.sum), 32'd0);
        check_eq("rst_zero", 32'(bus.zero), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);

        run_directed("t1_add",     4'b0011, 4'b0101, 1'b0, 5'b01000, 1'b0);
        run_directed("t2_add_neg", 4'b0011, 4'b1101, 1'b0, 5'b10010, 1'b0);
        run_directed("t2_sub",     4'b0011, 4'b0101, 1'b1, 5'b10010, 1'b0);
        run_directed("t3_negneg",  4'b1111, 4'b1111, 1'b0, 5'b11110, 1'b0);
        run_directed("t3_eqsub",   4'b0100, 4'b0100, 1'b1, 5'b00000, 1'b1);
        run_directed("t4_negzero", 4'b1000, 4'b1000, 1'b0, 5'b00000, 1'b1);

        // Six back-to-back ops with a 3-cycle sink stall in the middle
        for (int i = 0; i < 6; i++) begin
            sa[i]  = DW'($urandom);
            sb[i]  = DW'($urandom);
            sop[i] = 1'($urandom);
        end
        base = rx_cnt;
        idx  = 0;
        for (int k = 0; k < 40 && idx < 6; k++) begin
            @(posedge clk); #1;
            bus.out_ready = !(k >= 3 && k <= 5);
            bus.in_valid  = 1'b1;
            bus.a         = sa[idx];
            bus.b         = sb[idx];
            bus.op_sub    = sop[idx];
            @(negedge clk);
            if (k >= 3 && k <= 5) begin
                check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check_eq("stall_out_valid", 32'(bus.out_valid), 32'd1);
            end
            fire = bus.in_ready;
            if (fire) idx++;
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("stall_drain");
        check_eq("stall_count", 32'(rx_cnt - base), 32'd6);

        // Exhaustive sweep of every {a, b, op} at full rate
        base = rx_cnt;
        for (int i = 0; i < (1 << (2 * DW + 1)); i++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.op_sub    = 1'(i);
            bus.b         = DW'(i >> 1);
            bus.a         = DW'(i >> (DW + 1));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain("sweep_drain");
        check_eq("sweep_count", 32'(rx_cnt - base), 32'(1 << (2 * DW + 1)));

        // Random traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = DW'($urandom);
            bus.b         = DW'($urandom);
            bus.op_sub    = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("rand_drain");

        // Asynchronous reset with both stages full and stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.a        = DW'($urandom);
            bus.b        = DW'($urandom);
            bus.op_sub   = 1'($urandom);
        end
        check_eq("full_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_sum", 32'(bus.sum), 32'd0);
        check_eq("arst_zero", 32'(bus.zero), 32'd0);
        check_eq("arst_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_directed("post_rst", 4'b0011, 4'b0101, 1'b0, 5'b01000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
